// File: rtl/insn_loader_pkg.sv
// Shared constants, loader state encoding and length helper
// for the instruction memory write path.
package insn_loader_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int INSN_BYTES = 4;
  localparam int LEN_W      = ADDR_W + 1;
  localparam int MEM_WORDS  = 1 << ADDR_W;
  localparam int IDX_W      = $clog2(INSN_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_DONE
  } ld_state_t;

  // Clamp a requested word count to the memory depth.
  function automatic logic [LEN_W-1:0] sat_len(
    input logic [LEN_W-1:0] l
  );
    if (l > LEN_W'(MEM_WORDS))
      return LEN_W'(MEM_WORDS);
    return l;
  endfunction

endpackage

// File: rtl/insn_loader_if.sv
// Host byte stream, load control and memory write port
// of the instruction loader.
interface insn_loader_if;
  import insn_loader_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;

  modport master (
    output start,
    output len,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_hold,
    input  done
  );

  modport slave (
    input  start,
    input  len,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output done
  );

endinterface

// File: rtl/insn_loader_byte_to_word.sv
// Little-endian byte assembler: collects bytes 0..2, and on byte 3
// presents the full word together with a one-cycle word_valid.
module byte_to_word
  import insn_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              fire,
  input  logic [7:0]        data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-9:0] lo;

  assign word_valid = fire && (idx == IDX_W'(INSN_BYTES - 1));
  assign word       = {data, lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      lo  <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (fire) begin
      idx <= idx + IDX_W'(1);
      unique case (idx)
        2'd0:    lo[7:0]   <= data;
        2'd1:    lo[15:8]  <= data;
        2'd2:    lo[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/insn_loader.sv
// Loads a byte stream into instruction memory words 0..len-1 and
// keeps the core held in reset until the last word is written.
module insn_loader
  import insn_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  insn_loader_if.slave bus
);

  ld_state_t         state;
  ld_state_t         state_n;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready;
  logic              fire;
  logic              go;
  logic              last;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign ready = (state == S_LOAD);
  assign fire  = bus.byte_valid && ready;
  assign go    = bus.start &&
                 ((state == S_IDLE) || (state == S_DONE));
  assign last  = (cnt == len_q - LEN_W'(1));

  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .clear      (go),
    .fire       (fire),
    .data       (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start)
          state_n = (bus.len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (word_valid && last)
          state_n = S_FINISH;
      end
      S_FINISH: state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Write port is registered so addr/data are stable for the whole strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt     <= '0;
      addr    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= word_valid;
      if (go) begin
        len_q <= sat_len(bus.len);
        cnt   <= '0;
        addr  <= '0;
      end else if (word_valid) begin
        waddr_q <= addr;
        wdata_q <= word;
        addr    <= addr + ADDR_W'(1);
        cnt     <= cnt + LEN_W'(1);
      end
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_hold   = (state != S_DONE);
  assign bus.done       = (state == S_DONE);

endmodule

// File: doc/insn_loader.md
# insn_loader

Write-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them into the 32-bit x 1024 instruction memory at consecutive word indices starting at 0. It sits between the host byte source (UART receiver or testbench) and the memory write port. It holds the core in reset until a program load completes.

## Interface
- ADDR_W, 10, word-index width of the instruction memory (1024 words)
- DATA_W, 32, instruction width; fixed at 4 bytes per word
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load of `len` words
- len  input  ADDR_W+1  word count, sampled on `start`; values above 1024 saturate to 1024
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  next program byte
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  write strobe to the instruction memory, one cycle per word
- mem_addr  output  ADDR_W  word index being written
- mem_wdata  output  DATA_W  assembled instruction
- cpu_hold  output  1  keeps the core and PC in reset while high
- done  output  1  load complete; held until the next `start` or reset

## Operation
- States: IDLE, LOAD, FINISH, DONE. Reset forces IDLE.
- IDLE: byte_ready=0, cpu_hold=1, done=0. `start` with len=0 -> DONE. `start` with len>0 -> LOAD; latch len (saturated), clear word counter, byte index, and address.
- LOAD: byte_ready=1. A byte transfers when byte_valid && byte_ready. Byte k (k=0..3) of a word lands in bits [8k+7:8k] (little-endian). Bytes offered while byte_valid=0 are ignored; the source may stall indefinitely.
- On acceptance of byte 3: mem_wdata <= assembled word, mem_addr <= current address, mem_we <= 1 for exactly the next cycle. The address and word counter then increment, and the byte index returns to 0.
- If that word is the last one (count == len-1): -> FINISH instead of staying in LOAD.
- FINISH: byte_ready=0, mem_we=1 for the final word, cpu_hold=1. -> DONE unconditionally after one cycle.
- DONE: cpu_hold=0, done=1, byte_ready=0. `start` -> LOAD (reload from address 0), with done and cpu_hold re-asserted per LOAD rules.
- `start` in LOAD or FINISH is ignored.
- Address wraps 1023 -> 0 only in arithmetic. Saturation of len guarantees no write past index 1023.
- Reset mid-load: return to IDLE immediately. A partial word is discarded, with no write. Words already written remain in memory.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0.
- All outputs are registered or decoded from registered state. byte_ready is a pure function of state, with no combinational path from byte_valid.
- Write latency: mem_we is high in the cycle immediately after the 4th byte of a word is accepted.
- Throughput: one byte per cycle, sustained. Consecutive words produce mem_we pulses 4 cycles apart, and no byte is refused in LOAD.
- Release: cpu_hold falls and done rises one cycle after the final mem_we, so the memory holds the last word before the core fetches.
- mem_addr and mem_wdata are stable throughout each mem_we cycle and are don't-care otherwise.

## Structure
- A shared package holds ADDR_W, DATA_W, INSN_BYTES=4, and the loader state enum. The fetch side uses the same ADDR_W.
- A sub-module `byte_to_word` (byte index counter plus 32-bit shift/assemble register, emits word_valid) is natural. The FSM and address counter live in `insn_loader`.

## Test plan
- Reset: assert rst mid-cycle -> all outputs at reset values asynchronously. cpu_hold=1 and byte_ready=0 while rst is high.
- Single word: start, len=1, bytes 0x13,0x00,0x00,0x00 back-to-back -> one mem_we, addr 0, data 0x00000013. FINISH, then done=1 and cpu_hold=0 one cycle after the write.
- Stalled stream: len=2, byte_valid gated off for 3 cycles between every byte, words 0xDEADBEEF and 0x00500093 -> writes at addr 0 and 1 with correct data, and no extra mem_we.
- len=0: start -> DONE next cycle, with no mem_we. len=2047 -> saturates; exactly 1024 writes, addr 0..1023, and no wrap to 0.
- Reset mid-load: len=4, reset after 6 bytes -> only addr 0 written. After reset, in IDLE with cpu_hold=1 and no write of the partial word.
- Reload: after DONE, start with len=1 and word 0x00000073 -> done drops, cpu_hold rises, addr 0 rewritten, then done=1 again. start pulsed during LOAD has no effect.
